// File: rtl/preg_fre_lst.sv
// preg_fre_lst: circular free list of physical registers for rename.
// Each cycle it grants up to PORTS compacted pdest tags all-or-nothing and takes back up to PORTS released tags.
module preg_fre_lst #(
  parameter int NUM_PREG  = 64,
  parameter int PREG_BITS = 6,
  parameter int NUM_ARCH  = 16,
  parameter int PORTS     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PORTS-1:0]             alc_req,
  output logic [PORTS*PREG_BITS-1:0]   alc_preg_flat,
  output logic                         alc_gnt,
  output logic                         alc_stl,
  input  logic [PORTS*(PREG_BITS+1)-1:0] rcl_flat,
  output logic [PREG_BITS:0]           fre_cnt,
  output logic                         ovf_err
);
  localparam int CW = PREG_BITS + 1;
  logic [PREG_BITS-1:0] mem [NUM_PREG];
  logic [PREG_BITS-1:0] hd, tl;
  logic [CW-1:0] cnt, nreq, nrcl, nacc, grant;
  logic [CW:0] room;
  logic [PREG_BITS-1:0] aoff [PORTS];
  logic [CW-1:0] roff [PORTS];
  logic [PORTS-1:0] acc;
  assign fre_cnt = cnt;
  always_comb begin
    nreq = '0;
    nrcl = '0;
    for (int i = 0; i < PORTS; i++) begin
      aoff[i] = nreq[PREG_BITS-1:0];
      roff[i] = nrcl;
      nreq = nreq + CW'(alc_req[i]);
      nrcl = nrcl + CW'(rcl_flat[CW*i+PREG_BITS]);
    end
    alc_stl = nreq > cnt;
    alc_gnt = (nreq != '0) && !alc_stl;
    grant = alc_gnt ? nreq : '0;
    // free slots left for pushes once this cycle's grant has been popped
    room = (CW+1)'(NUM_PREG) - {1'b0, cnt} + {1'b0, grant};
    alc_preg_flat = '0;
    acc = '0;
    nacc = '0;
    for (int i = 0; i < PORTS; i++) begin
      alc_preg_flat[PREG_BITS*i +: PREG_BITS] = alc_req[i] ? mem[hd + aoff[i]] : '0;
      acc[i] = rcl_flat[CW*i+PREG_BITS] && ({1'b0, roff[i]} < room);
      nacc = nacc + CW'(acc[i]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PREG; k++)
        mem[k] <= (k < NUM_PREG - NUM_ARCH) ? PREG_BITS'(NUM_ARCH + k) : '0;
      hd <= '0;
      tl <= PREG_BITS'(NUM_PREG - NUM_ARCH);
      cnt <= CW'(NUM_PREG - NUM_ARCH);
      ovf_err <= 1'b0;
    end else begin
      hd <= hd + grant[PREG_BITS-1:0];
      tl <= tl + nacc[PREG_BITS-1:0];
      cnt <= cnt - grant + nacc;
      if ({1'b0, nrcl} > room) ovf_err <= 1'b1;
      for (int i = 0; i < PORTS; i++)
        if (acc[i]) mem[tl + roff[i][PREG_BITS-1:0]] <= rcl_flat[CW*i +: PREG_BITS];
    end
  end
endmodule

// File: tb/tb_preg_fre_lst.sv
// tb_preg_fre_lst: directed stimulus against a queue-based free-list model plus hand-computed pins.
module tb_preg_fre_lst;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] alc_req;
  logic [23:0] alc_preg_flat;
  logic alc_gnt, alc_stl, ovf_err;
  logic [27:0] rcl_flat;
  logic [6:0] fre_cnt;
  int checks = 0, errors = 0;
  int q[$];
  bit movf;
  int mn, cn, cj;
  logic [23:0] prev;

  preg_fre_lst dut (
    .clk(clk), .rst_n(rst_n), .alc_req(alc_req), .alc_preg_flat(alc_preg_flat),
    .alc_gnt(alc_gnt), .alc_stl(alc_stl), .rcl_flat(rcl_flat), .fre_cnt(fre_cnt),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic int slot(input int i);
    return int'(alc_preg_flat[6*i +: 6]);
  endfunction

  function automatic logic [27:0] pk(input logic [3:0] v, input logic [23:0] t);
    logic [27:0] r;
    for (int i = 0; i < 4; i++) r[7*i +: 7] = {v[i], t[6*i +: 6]};
    return r;
  endfunction

  // model: an ordered list of free tags, popped from the front and pushed at the back
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      for (int k = 0; k < 48; k++) q.push_back(16 + k);
      movf = 1'b0;
    end else begin
      mn = $countones(alc_req);
      if (mn != 0 && mn <= q.size()) repeat (mn) void'(q.pop_front());
      for (int i = 0; i < 4; i++)
        if (rcl_flat[7*i+6]) begin
          if (q.size() < 64) q.push_back(int'(rcl_flat[7*i +: 6]));
          else movf = 1'b1;
        end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      cn = $countones(alc_req);
      chk("alc_stl", int'(alc_stl), int'(cn > q.size()));
      chk("alc_gnt", int'(alc_gnt), int'(cn != 0 && cn <= q.size()));
      chk("fre_cnt", int'(fre_cnt), q.size());
      chk("ovf_err", int'(ovf_err), int'(movf));
      cj = 0;
      for (int i = 0; i < 4; i++)
        if (alc_req[i]) begin
          if (cn <= q.size()) chk($sformatf("slot%0d", i), slot(i), q[cj]);
          cj++;
        end else chk($sformatf("idle_slot%0d", i), slot(i), 0);
    end
  end

  task automatic drive(input logic [3:0] r, input logic [27:0] c);
    @(posedge clk);
    #1;
    alc_req = r;
    rcl_flat = c;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    alc_req = '0;
    rcl_flat = '0;
    #1;
    chk("rst_cnt", int'(fre_cnt), 48);
    chk("rst_ovf", int'(ovf_err), 0);
    chk("rst_gnt", int'(alc_gnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    alc_req = '0;
    rcl_flat = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("init_cnt", int'(fre_cnt), 48);
    chk("init_stl", int'(alc_stl), 0);
    drive(4'b1111, '0);
    chk("t1_gnt", int'(alc_gnt), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_slot%0d", i), slot(i), 16 + i);
    drive(4'b0000, '0);
    chk("t1_cnt", int'(fre_cnt), 44);

    do_reset();
    drive(4'b1010, '0);
    chk("t2_s0", slot(0), 0);
    chk("t2_s1", slot(1), 16);
    chk("t2_s2", slot(2), 0);
    chk("t2_s3", slot(3), 17);
    drive(4'b0000, '0);
    chk("t2_cnt", int'(fre_cnt), 46);

    do_reset();
    repeat (12) drive(4'b1111, '0);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_slot%0d", i), slot(i), 60 + i);
    drive(4'b0000, '0);
    chk("t3_cnt", int'(fre_cnt), 0);
    drive(4'b0001, '0);
    chk("t3_stl", int'(alc_stl), 1);
    chk("t3_gnt", int'(alc_gnt), 0);

    do_reset();
    repeat (11) drive(4'b1111, '0);
    drive(4'b0011, '0);
    drive(4'b0000, '0);
    chk("t4_cnt2", int'(fre_cnt), 2);
    drive(4'b0111, pk(4'b0101, {6'd0, 6'd33, 6'd0, 6'd20}));
    chk("t4_stl", int'(alc_stl), 1);
    drive(4'b0000, '0);
    chk("t4_cnt4", int'(fre_cnt), 4);
    drive(4'b0111, '0);
    chk("t4_s0", slot(0), 62);
    chk("t4_s1", slot(1), 63);
    chk("t4_s2", slot(2), 20);

    do_reset();
    prev = {6'd3, 6'd2, 6'd1, 6'd0};
    for (int c = 0; c < 40; c++) begin
      drive(4'b1111, pk(4'b1111, prev));
      prev = {6'(q[3]), 6'(q[2]), 6'(q[1]), 6'(q[0])};
      if (c == 12)
        for (int i = 0; i < 4; i++) chk($sformatf("t5_recycle%0d", i), slot(i), i);
    end
    drive(4'b0000, '0);
    chk("t5_cnt", int'(fre_cnt), 48);

    do_reset();
    drive(4'b0000, pk(4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}));
    drive(4'b0000, pk(4'b1111, {6'd7, 6'd6, 6'd5, 6'd4}));
    drive(4'b0000, pk(4'b1111, {6'd11, 6'd10, 6'd9, 6'd8}));
    drive(4'b0000, pk(4'b0011, {6'd0, 6'd0, 6'd13, 6'd12}));
    drive(4'b0000, '0);
    chk("t6_cnt62", int'(fre_cnt), 62);
    chk("t6_ovf0", int'(ovf_err), 0);
    drive(4'b0000, pk(4'b1111, {6'd42, 6'd41, 6'd15, 6'd14}));
    drive(4'b0000, '0);
    chk("t6_cnt64", int'(fre_cnt), 64);
    chk("t6_ovf1", int'(ovf_err), 1);
    repeat (3) drive(4'b0000, '0);
    chk("t6_sticky", int'(ovf_err), 1);
    drive(4'b1111, '0);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_slot%0d", i), slot(i), 16 + i);
    do_reset();
    drive(4'b0000, '0);
    chk("t6_ovf_clr", int'(ovf_err), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
